// File: rtl/rv_core_pkg.sv
// Shared core constants for the write-back path: register file geometry,
// requester count and the fixed requester identifiers.
package rv_core_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  localparam int WB_NUM_REQ = 3;
  localparam int WB_ID_W    = $clog2(WB_NUM_REQ);

  localparam logic [WB_ID_W-1:0] WB_ALU = 2'd0;
  localparam logic [WB_ID_W-1:0] WB_LSU = 2'd1;
  localparam logic [WB_ID_W-1:0] WB_CSR = 2'd2;

endpackage : rv_core_pkg

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: starting at ptr, the first asserted request
// wins. Produces a one-hot grant, the encoded winner and an any-grant flag.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_winner,
  output logic               o_any_grant
);

  logic [ID_W:0]   w_idx_wide;
  logic [ID_W-1:0] w_idx;

  // Scan requesters from the pointer with wrap-around by explicit compare (non-power-of-2 safe).
  always_comb begin
    o_grant     = '0;
    o_winner    = '0;
    o_any_grant = 1'b0;
    w_idx_wide  = '0;
    w_idx       = '0;
    if (i_enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_idx_wide = {1'b0, i_ptr} + (ID_W+1)'(k);
        if (w_idx_wide >= (ID_W+1)'(NUM_REQ)) begin
          w_idx_wide = w_idx_wide - (ID_W+1)'(NUM_REQ);
        end else begin
          w_idx_wide = w_idx_wide;
        end
        w_idx = w_idx_wide[ID_W-1:0];
        if (!o_any_grant && i_req[w_idx]) begin
          o_grant[w_idx] = 1'b1;
          o_winner       = w_idx;
          o_any_grant    = 1'b1;
        end else begin
          o_any_grant = o_any_grant;
        end
      end
    end else begin
      o_any_grant = 1'b0;
    end
  end

endmodule : rr_arbiter

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: round-robin selects one write-back requester
// per cycle, registers its write for one cycle and drives the register file.
// Writes to x0 complete the handshake but are not performed.
module regfile_wb_arbiter
  import rv_core_pkg::*;
#(
  parameter int NUM_REQ = WB_NUM_REQ,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = XLEN,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_dest,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      hold,
  output logic                      rf_write_enable,
  output logic [ADDR_W-1:0]         rf_dest,
  output logic [DATA_W-1:0]         rf_data,
  output logic [ID_W-1:0]           rf_grant_id
);

  logic [ID_W-1:0]    r_rr_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_winner;
  logic               w_any_grant;
  logic               w_enable;
  logic [ADDR_W-1:0]  w_dest;
  logic [DATA_W-1:0]  w_data;
  logic [ID_W-1:0]    w_next_ptr;

  // No grants during reset or stall; grant never depends on rf_* state.
  assign w_enable  = reset & ~hold;
  assign req_ready = w_grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .i_req       (req_valid),
    .i_ptr       (r_rr_ptr),
    .i_enable    (w_enable),
    .o_grant     (w_grant),
    .o_winner    (w_winner),
    .o_any_grant (w_any_grant)
  );

  // Select the winner's payload and the pointer position just past it.
  always_comb begin
    w_dest = req_dest[w_winner*ADDR_W +: ADDR_W];
    w_data = req_data[w_winner*DATA_W +: DATA_W];
    if (w_winner == ID_W'(NUM_REQ-1)) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = w_winner + ID_W'(1);
    end
  end

  // Capture the winning write and advance the pointer; an idle cycle only clears the enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_write_enable <= 1'b0;
      rf_dest         <= '0;
      rf_data         <= '0;
      rf_grant_id     <= '0;
      r_rr_ptr        <= '0;
    end else if (w_any_grant) begin
      rf_write_enable <= (w_dest != ADDR_W'(REG_X0));
      rf_dest         <= w_dest;
      rf_data         <= w_data;
      rf_grant_id     <= w_winner;
      r_rr_ptr        <= w_next_ptr;
    end else begin
      rf_write_enable <= 1'b0;
    end
  end

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NUM_REQ=3).
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid;
  logic [14:0] req_dest;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        hold;
  logic        rf_write_enable;
  logic [4:0]  rf_dest;
  logic [31:0] rf_data;
  logic [1:0]  rf_grant_id;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_dest        (req_dest),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .hold            (hold),
    .rf_write_enable (rf_write_enable),
    .rf_dest         (rf_dest),
    .rf_data         (rf_data),
    .rf_grant_id     (rf_grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    hold      = 1'b0;
    req_valid = 3'b111;
    req_dest  = '0;
    req_data  = '0;
    #2;
    // 1. reset with all requesters valid
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_we", 64'(rf_write_enable), 64'h0);
    chk("rst_dest", 64'(rf_dest), 64'h0);
    chk("rst_data", 64'(rf_data), 64'h0);
    chk("rst_id", 64'(rf_grant_id), 64'h0);
    tick();
    tick();
    chk("rst_ready_hold", 64'(req_ready), 64'h0);
    reset = 1'b1;
    #1;
    chk("first_grant", 64'(req_ready), 64'h1);
    req_valid = 3'b000;
    tick();
    chk("idle_we", 64'(rf_write_enable), 64'h0);

    // 2. single request from requester 1
    req_valid      = 3'b010;
    req_dest[9:5]  = 5'd7;
    req_data[63:32] = 32'hDEADBEEF;
    #1;
    chk("t2_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = 3'b000;
    chk("t2_we", 64'(rf_write_enable), 64'h1);
    chk("t2_dest", 64'(rf_dest), 64'h7);
    chk("t2_data", 64'(rf_data), 64'hDEADBEEF);
    chk("t2_id", 64'(rf_grant_id), 64'h1);
    chk("t2_ptr", 64'(dut.r_rr_ptr), 64'h2);

    // 4. requester 2 writes x0: acknowledged, not performed, pointer wraps
    req_valid        = 3'b100;
    req_dest[14:10]  = 5'd0;
    req_data[95:64]  = 32'h00001234;
    #1;
    chk("t4_ready", 64'(req_ready), 64'h4);
    tick();
    req_valid = 3'b000;
    chk("t4_we", 64'(rf_write_enable), 64'h0);
    chk("t4_id", 64'(rf_grant_id), 64'h2);
    chk("t4_data", 64'(rf_data), 64'h1234);
    chk("t4_ptr", 64'(dut.r_rr_ptr), 64'h0);

    // 3. all three valid for six cycles: grant order 0,1,2,0,1,2
    req_dest  = {5'd3, 5'd2, 5'd1};
    req_data  = {32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      logic [2:0]  exp_oh;
      logic [31:0] exp_data;
      exp_oh   = 3'b001 << (c % 3);
      exp_data = (c % 3 == 0) ? 32'hA0A0A0A0 : ((c % 3 == 1) ? 32'hB1B1B1B1 : 32'hC2C2C2C2);
      #1;
      chk("t3_ready", 64'(req_ready), 64'(exp_oh));
      tick();
      chk("t3_we", 64'(rf_write_enable), 64'h1);
      chk("t3_id", 64'(rf_grant_id), 64'(c % 3));
      chk("t3_dest", 64'(rf_dest), 64'((c % 3) + 1));
      chk("t3_data", 64'(rf_data), 64'(exp_data));
    end

    // 5. hold asserted with requesters 0 and 1 valid
    req_valid = 3'b011;
    hold      = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t5_ready", 64'(req_ready), 64'h0);
      tick();
      chk("t5_we", 64'(rf_write_enable), 64'h0);
      chk("t5_ptr", 64'(dut.r_rr_ptr), 64'h0);
      chk("t5_id_held", 64'(rf_grant_id), 64'h2);
      chk("t5_dest_held", 64'(rf_dest), 64'h3);
    end
    hold = 1'b0;
    #1;
    chk("t5_resume_ready", 64'(req_ready), 64'h1);
    tick();
    chk("t5_resume_we", 64'(rf_write_enable), 64'h1);
    chk("t5_resume_id", 64'(rf_grant_id), 64'h0);
    chk("t5_resume_ptr", 64'(dut.r_rr_ptr), 64'h1);

    // 6. asynchronous reset while a write is on rf_*
    req_valid = 3'b111;
    #1;
    reset = 1'b0;
    #1;
    chk("t6_we_async", 64'(rf_write_enable), 64'h0);
    chk("t6_dest_async", 64'(rf_dest), 64'h0);
    chk("t6_ready", 64'(req_ready), 64'h0);
    chk("t6_ptr", 64'(dut.r_rr_ptr), 64'h0);
    tick();
    chk("t6_we_after", 64'(rf_write_enable), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
